// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers beam column/row from HSync/VSync, checks line and
// frame timing, and reports lock, timing errors and pixel data aligned to the beam.
module vga_sync_receiver #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FPORCH    = 16,
    parameter int unsigned H_MAX       = 800,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FPORCH    = 10,
    parameter int unsigned V_MAX       = 525,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_HSync,
    input  logic       i_VSync,
    input  logic [8:0] i_RGB,
    output logic [9:0] o_Column,
    output logic [9:0] o_Row,
    output logic [8:0] o_RGB,
    output logic       o_Pixel_Valid,
    output logic       o_Frame_Start,
    output logic       o_Locked,
    output logic       o_H_Err,
    output logic       o_V_Err,
    output logic [7:0] o_Err_Count
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        HLOCK  = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam logic [9:0]  H_SYNC_COL = 10'(H_ACTIVE + H_FPORCH);
    localparam logic [9:0]  H_LAST     = 10'(H_MAX - 1);
    localparam logic [9:0]  H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]  V_LOAD_ROW = 10'(V_ACTIVE + V_FPORCH);
    localparam logic [9:0]  V_LAST     = 10'(V_MAX - 1);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [11:0] LINE_LEN   = 12'(H_MAX);
    localparam logic [11:0] FRAME_LAST = 12'(V_MAX - 1);
    localparam logic [11:0] VS_WINDOW  = 12'(V_MAX + 1);
    localparam logic [11:0] CNT_SAT    = '1;
    localparam logic [7:0]  LOCK_GOAL  = 8'(LOCK_FRAMES);

    state_e      state_q, state_d;
    logic        hs1_q, hs1_d, vs1_q, vs1_d;
    logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [8:0]  rgb1_q, rgb1_d;
    logic [11:0] line_cnt_q, line_cnt_d;
    logic        h_seen_q, h_seen_d;
    logic        v_pend_q, v_pend_d;
    logic        v_seen_q, v_seen_d;
    logic [11:0] frame_cnt_q, frame_cnt_d;
    logic [11:0] vs_age_q, vs_age_d;
    logic [7:0]  good_cnt_q, good_cnt_d;
    logic [9:0]  column_q, column_d;
    logic [9:0]  row_q, row_d;
    logic [8:0]  rgb_q, rgb_d;
    logic        pix_valid_q, pix_valid_d;
    logic        frame_start_q, frame_start_d;
    logic        locked_q, locked_d;
    logic        h_err_q, h_err_d;
    logic        v_err_q, v_err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic h_fall, v_fall, wrap, v_load, row_wrap;
    logic h_err, h_good, frame_good, frame_bad, vs_missing, v_err, leave_lock;

    always_comb begin
        hs1_d     = i_HSync;
        vs1_d     = i_VSync;
        rgb1_d    = i_RGB;
        hs_prev_d = hs1_q;
        vs_prev_d = vs1_q;
        state_d    = state_q;
        good_cnt_d = good_cnt_q;

        // column_q/row_q double as the coordinate history of the previous sample
        h_fall   = hs_prev_q & ~hs1_q;
        v_fall   = vs_prev_q & ~vs1_q;
        wrap     = ~h_fall & (column_q == H_LAST);
        v_load   = wrap & (v_pend_q | v_fall);
        row_wrap = wrap & ~v_load & (row_q == V_LAST);

        if (h_fall)    column_d = H_SYNC_COL;
        else if (wrap) column_d = '0;
        else           column_d = column_q + 10'd1;

        if (v_load)        row_d = V_LOAD_ROW;
        else if (row_wrap) row_d = '0;
        else if (wrap)     row_d = row_q + 10'd1;
        else               row_d = row_q;

        h_err      = h_fall & h_seen_q & (line_cnt_q != LINE_LEN);
        h_good     = h_fall & h_seen_q & (line_cnt_q == LINE_LEN);
        frame_good = v_load & v_seen_q & (frame_cnt_q == FRAME_LAST);
        frame_bad  = v_load & v_seen_q & (frame_cnt_q != FRAME_LAST);
        vs_missing = row_wrap & (vs_age_q >= VS_WINDOW);
        v_err      = frame_bad | vs_missing;

        if (h_fall)                     line_cnt_d = 12'd1;
        else if (line_cnt_q != CNT_SAT) line_cnt_d = line_cnt_q + 12'd1;
        else                            line_cnt_d = line_cnt_q;

        if (v_load)                               frame_cnt_d = '0;
        else if (wrap && frame_cnt_q != CNT_SAT)  frame_cnt_d = frame_cnt_q + 12'd1;
        else                                      frame_cnt_d = frame_cnt_q;

        // After a missing VSync the next load starts a fresh measurement
        if (vs_missing)  v_seen_d = 1'b0;
        else if (v_load) v_seen_d = 1'b1;
        else             v_seen_d = v_seen_q;

        if (v_load)      v_pend_d = 1'b0;
        else if (v_fall) v_pend_d = 1'b1;
        else             v_pend_d = v_pend_q;

        if (v_fall)                             vs_age_d = '0;
        else if (wrap && vs_age_q != VS_WINDOW) vs_age_d = vs_age_q + 12'd1;
        else                                    vs_age_d = vs_age_q;

        unique case (state_q)
            SEARCH: begin
                if (h_good) begin
                    state_d    = HLOCK;
                    good_cnt_d = '0;
                end
            end
            HLOCK: begin
                if (h_err) begin
                    state_d = SEARCH;
                end else if (frame_good) begin
                    if (good_cnt_q + 8'd1 >= LOCK_GOAL) state_d = LOCKED;
                    else                                good_cnt_d = good_cnt_q + 8'd1;
                end else if (v_err) begin
                    good_cnt_d = '0;
                end
            end
            LOCKED: begin
                if (h_err || v_err) state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase

        leave_lock = (state_q != SEARCH) && (state_d == SEARCH);
        if (leave_lock)  h_seen_d = 1'b0;
        else if (h_fall) h_seen_d = 1'b1;
        else             h_seen_d = h_seen_q;

        locked_d      = (state_d == LOCKED);
        rgb_d         = rgb1_q;
        pix_valid_d   = locked_d && (column_d < H_ACT) && (row_d < V_ACT);
        frame_start_d = locked_d && (column_d == '0) && (row_d == '0);
        h_err_d       = h_err;
        v_err_d       = v_err;
        if ((h_err || v_err) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        else                                       err_cnt_d = err_cnt_q;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q       <= SEARCH;
            hs1_q         <= 1'b1;
            vs1_q         <= 1'b1;
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            rgb1_q        <= '0;
            line_cnt_q    <= '0;
            h_seen_q      <= 1'b0;
            v_pend_q      <= 1'b0;
            v_seen_q      <= 1'b0;
            frame_cnt_q   <= '0;
            vs_age_q      <= '0;
            good_cnt_q    <= '0;
            column_q      <= '0;
            row_q         <= '0;
            rgb_q         <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            h_err_q       <= 1'b0;
            v_err_q       <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            rgb1_q        <= rgb1_d;
            line_cnt_q    <= line_cnt_d;
            h_seen_q      <= h_seen_d;
            v_pend_q      <= v_pend_d;
            v_seen_q      <= v_seen_d;
            frame_cnt_q   <= frame_cnt_d;
            vs_age_q      <= vs_age_d;
            good_cnt_q    <= good_cnt_d;
            column_q      <= column_d;
            row_q         <= row_d;
            rgb_q         <= rgb_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            h_err_q       <= h_err_d;
            v_err_q       <= v_err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign o_Column      = column_q;
    assign o_Row         = row_q;
    assign o_RGB         = rgb_q;
    assign o_Pixel_Valid = pix_valid_q;
    assign o_Frame_Start = frame_start_q;
    assign o_Locked      = locked_q;
    assign o_H_Err       = h_err_q;
    assign o_V_Err       = v_err_q;
    assign o_Err_Count   = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver using a reduced 20x10 mode
// (32 clocks/line, 16 lines/frame) so several frames fit in a short run.
module tb_vga_sync_receiver;

    localparam int unsigned HA = 20, HF = 4, HM = 32;
    localparam int unsigned VA = 10, VF = 2, VM = 16;
    localparam int unsigned FRAME = HM * VM;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_HSync, i_VSync;
    logic [8:0] i_RGB;
    logic [9:0] o_Column, o_Row;
    logic [8:0] o_RGB;
    logic       o_Pixel_Valid, o_Frame_Start, o_Locked, o_H_Err, o_V_Err;
    logic [7:0] o_Err_Count;

    vga_sync_receiver #(
        .H_ACTIVE(HA), .H_FPORCH(HF), .H_MAX(HM),
        .V_ACTIVE(VA), .V_FPORCH(VF), .V_MAX(VM), .LOCK_FRAMES(2)
    ) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_HSync(i_HSync), .i_VSync(i_VSync),
        .i_RGB(i_RGB), .o_Column(o_Column), .o_Row(o_Row), .o_RGB(o_RGB),
        .o_Pixel_Valid(o_Pixel_Valid), .o_Frame_Start(o_Frame_Start),
        .o_Locked(o_Locked), .o_H_Err(o_H_Err), .o_V_Err(o_V_Err),
        .o_Err_Count(o_Err_Count)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0, failures = 0;
    int unsigned gcol, grow, sidx;
    int unsigned p_col, p_row, p_idx, c_col, c_row, c_idx;
    int unsigned obs_col, obs_row, obs_idx;
    bit          ovr_en, alt, vs_off, lk_prev;
    int unsigned ovr_row;
    int unsigned n_herr, n_verr, nloads;
    int unsigned lock_events, lock_idx, lock_col, lock_row, lock_loads;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned line_len();
        if (alt) return (grow % 2 == 1) ? 33 : 31;
        if (ovr_en && grow == ovr_row) return 31;
        return HM;
    endfunction

    task automatic restart_gen();
        gcol = 0; grow = 0; sidx = 0;
        p_col = 999; p_row = 999; p_idx = 32'hFFFF_FFFF;
        ovr_en = 0; alt = 0; vs_off = 0; lk_prev = 0;
    endtask

    // Drive one generator sample; afterwards outputs describe the previous sample (obs_*).
    task automatic step();
        int unsigned len;
        i_HSync = !(gcol >= HA + HF && gcol < HA + HF + 4);
        i_VSync = vs_off || !(grow >= VA + VF && grow < VA + VF + 2);
        i_RGB   = (gcol == 5 && grow == 7) ? 9'h1FC : 9'(gcol * 7 + grow);
        c_col = gcol; c_row = grow; c_idx = sidx;
        @(posedge clk); #1;
        obs_col = p_col; obs_row = p_row; obs_idx = p_idx;
        n_herr += o_H_Err;
        n_verr += o_V_Err;
        if (o_Row == 10'(VA + VF) && o_Column == 10'd0) nloads++;
        if (o_Locked && !lk_prev) begin
            lock_events++;
            lock_idx = obs_idx; lock_col = o_Column; lock_row = o_Row; lock_loads = nloads;
        end
        lk_prev = o_Locked;
        p_col = c_col; p_row = c_row; p_idx = c_idx;
        len = line_len();
        if (gcol == len - 1) begin
            gcol = 0;
            if (ovr_en && grow == ovr_row) ovr_en = 0;
            grow = (grow == VM - 1) ? 0 : grow + 1;
        end else begin
            gcol++;
        end
        sidx++;
    endtask

    task automatic run_until(input int unsigned col, input int unsigned row,
                             input int unsigned limit, input string tag);
        int unsigned n = 0;
        do begin
            step();
            n++;
        end while (!(obs_col == col && obs_row == row) && n < limit);
        if (!(obs_col == col && obs_row == row)) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_lock(input int unsigned limit);
        int unsigned n = 0;
        lock_events = 0;
        while (lock_events == 0 && n < limit) begin
            step();
            n++;
        end
    endtask

    // Lock rises at the load of frame 2 (frame 0 load unchecked, frames 1 and 2 good).
    task automatic acquire(input string tag);
        n_herr = 0; n_verr = 0; nloads = 0;
        wait_lock(4 * FRAME);
        check_eq({tag, "_lock_seen"}, lock_events, 1);
        check_eq({tag, "_lock_idx"}, lock_idx, 2 * FRAME + (VA + VF) * HM);
        check_eq({tag, "_lock_col"}, lock_col, 0);
        check_eq({tag, "_lock_row"}, lock_row, VA + VF);
        check_eq({tag, "_herr"}, n_herr, 0);
        check_eq({tag, "_verr"}, n_verr, 0);
        check_eq({tag, "_errcnt"}, o_Err_Count, 0);
    endtask

    task automatic idle_pins();
        i_HSync = 1'b1; i_VSync = 1'b1; i_RGB = 9'h155;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_col"}, o_Column, 0);
        check_eq({tag, "_row"}, o_Row, 0);
        check_eq({tag, "_rgb"}, o_RGB, 0);
        check_eq({tag, "_valid"}, o_Pixel_Valid, 0);
        check_eq({tag, "_fstart"}, o_Frame_Start, 0);
        check_eq({tag, "_locked"}, o_Locked, 0);
        check_eq({tag, "_herr"}, o_H_Err, 0);
        check_eq({tag, "_verr"}, o_V_Err, 0);
        check_eq({tag, "_errcnt"}, o_Err_Count, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        rst_n = 1'b0;
        idle_pins();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        rst_n = 1'b1;
        restart_gen();
        acquire("acq");

        run_until(5, 7, 2 * FRAME, "pix");
        check_eq("pix_col", o_Column, 5);
        check_eq("pix_row", o_Row, 7);
        check_eq("pix_rgb", o_RGB, 9'h1FC);
        check_eq("pix_valid", o_Pixel_Valid, 1);
        run_until(HA, 7, HM, "hblank");
        check_eq("hblank_col", o_Column, HA);
        check_eq("hblank_valid", o_Pixel_Valid, 0);
        run_until(HA - 1, VA - 1, FRAME, "lastpix");
        check_eq("lastpix_valid", o_Pixel_Valid, 1);
        run_until(0, VA, FRAME, "vblank");
        check_eq("vblank_valid", o_Pixel_Valid, 0);
        run_until(0, 0, FRAME, "fstart");
        check_eq("fstart_on", o_Frame_Start, 1);
        step();
        check_eq("fstart_off", o_Frame_Start, 0);

        // One 31-clock line on row 3: the short line is measured at the row 4 fall.
        run_until(0, 2, FRAME, "short_pre");
        ovr_en = 1; ovr_row = 3; n_herr = 0; n_verr = 0;
        n = 0;
        do begin step(); n++; end while (!o_H_Err && n < 200);
        check_eq("short_herr", o_H_Err, 1);
        check_eq("short_locked", o_Locked, 0);
        check_eq("short_errcnt", o_Err_Count, 1);
        check_eq("short_col", o_Column, HA + HF);
        check_eq("short_row", o_Row, 4);
        nloads = 0;
        wait_lock(3 * FRAME);
        check_eq("relock_seen", lock_events, 1);
        check_eq("relock_loads", lock_loads, 2);
        check_eq("relock_herr", n_herr, 1);
        check_eq("relock_verr", n_verr, 0);

        // Suppress VSync for one frame; the missing-VSync window expires at the next row wrap.
        run_until(0, 0, FRAME, "vmiss_pre");
        vs_off = 1; n_verr = 0; n_herr = 0;
        run_until(0, VM - 1, FRAME, "vmiss_mid");
        vs_off = 0;
        n = 0;
        do begin step(); n++; end while (!o_V_Err && n < 2 * FRAME);
        check_eq("vmiss_verr", o_V_Err, 1);
        check_eq("vmiss_col", o_Column, 0);
        check_eq("vmiss_row", o_Row, 0);
        check_eq("vmiss_locked", o_Locked, 0);
        check_eq("vmiss_errcnt", o_Err_Count, 2);
        nloads = 0;
        run_until(0, VA + VF, FRAME, "vmiss_load");
        check_eq("vmiss_load_row", o_Row, VA + VF);
        check_eq("vmiss_load_verr", n_verr, 1);
        wait_lock(4 * FRAME);
        check_eq("vrelock_seen", lock_events, 1);
        check_eq("vrelock_loads", lock_loads, 3);
        check_eq("vrelock_verr", n_verr, 1);
        check_eq("vrelock_herr", n_herr, 0);

        // Asynchronous reset mid-line while locked.
        run_until(10, 5, FRAME, "arst_pre");
        check_eq("arst_pre_locked", o_Locked, 1);
        check_eq("arst_pre_errcnt", o_Err_Count, 2);
        rst_n = 1'b0;
        #1;
        check_all_zero("arst");
        idle_pins();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        restart_gen();
        acquire("reacq");

        // Alternating 31/33-clock lines drive the error counter into saturation.
        alt = 1; n_herr = 0;
        for (int i = 0; i < 11000; i++) step();
        check_eq("sat_errcnt", o_Err_Count, 255);
        check_eq("sat_many_herr", (n_herr >= 300) ? 1 : 0, 1);
        alt = 0;
        for (int i = 0; i < 200; i++) step();
        check_eq("sat_hold", o_Err_Count, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
